// File: rtl/toeplitz_coef_arb.sv
`default_nettype none
// ============================================================================
// Module   : toeplitz_coef_arb
// Purpose  : Round-robin arbiter sharing one coefficient FIFO read port among
//            Toeplitz hash lanes; fixed-length burst per grant.
//            Optional macro COEF_ARB_STATS_EN adds the words_total counter.
// Revision : 1.0 - initial release
// ============================================================================
module toeplitz_coef_arb #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 8,
    parameter int DATA_W    = 3
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    input  logic               fifo_empty,
    output logic               fifo_read,
    input  logic [DATA_W-1:0]  fifo_q,
    output logic [DATA_W-1:0]  coef_out,
    output logic [NUM_REQ-1:0] coef_valid,
    output logic [NUM_REQ-1:0] burst_done
`ifdef COEF_ARB_STATS_EN
    ,
    output logic [15:0]        words_total
`endif
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int RR_W  = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] c_burst_len = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] c_last_idx  = CNT_W'(BURST_LEN - 1);
    localparam logic [RR_W-1:0]  c_last_req  = RR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [RR_W-1:0]    r_rr;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_delivered;
    logic               r_rd_d1;
    logic               w_arb_load;
    logic               w_found;
    logic [RR_W-1:0]    w_win;
    logic [RR_W-1:0]    w_idx;
    logic [RR_W-1:0]    w_rr_next;
    logic [NUM_REQ-1:0] w_grant_next;

    // First requesting lane at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = RR_W'((int'(r_rr) + i) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_rr_next    = (w_win == c_last_req) ? '0 : w_win + 1'b1;
    assign w_grant_next = NUM_REQ'(1) << w_win;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        fifo_read    = 1'b0;
        w_arb_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_arb_load   = 1'b1;
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                if (!fifo_empty && (r_issued < c_burst_len)) begin
                    fifo_read = 1'b1;
                    if (r_issued == c_last_idx) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (|burst_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            r_rr        <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_rd_d1     <= 1'b0;
            coef_out    <= '0;
            coef_valid  <= '0;
            burst_done  <= '0;
        end else begin
            r_rd_d1 <= fifo_read;

            if (w_arb_load) begin
                grant       <= w_grant_next;
                r_rr        <= w_rr_next;
                r_issued    <= '0;
                r_delivered <= '0;
            end else if ((r_state == S_DRAIN) && (|burst_done)) begin
                grant <= '0;
            end

            if (fifo_read) begin
                r_issued <= r_issued + 1'b1;
            end

            // The FIFO word lands one cycle after rdreq; grant is still held here.
            if (r_rd_d1) begin
                coef_out    <= fifo_q;
                coef_valid  <= grant;
                r_delivered <= r_delivered + 1'b1;
                burst_done  <= (r_delivered == c_last_idx) ? grant : '0;
            end else begin
                coef_valid <= '0;
                burst_done <= '0;
            end
        end
    end

`ifdef COEF_ARB_STATS_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            words_total <= '0;
        end else if ((|coef_valid) && (words_total != 16'hFFFF)) begin
            words_total <= words_total + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
